// File: rtl/rps_match_master.sv
// Rock-paper-scissors match sequencer: gathers the player move, generates an opponent move,
// hands both to an external evaluator, then tallies verdicts until one side reaches the target.
module rps_match_master (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_match,
    input  logic [2:0] target_cfg,
    input  logic       p1_valid,
    input  logic [1:0] p1_move_in,
    input  logic       force_en,
    input  logic [1:0] force_move,
    output logic       eval_start,
    output logic [1:0] p1_move_out,
    output logic [1:0] p2_move_out,
    input  logic [1:0] result_in,
    input  logic       result_valid,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic [3:0] round_cnt,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic       busy,
    output logic       err_invalid,
    output logic       err_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_TALLY = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] r_state;
    logic [7:0] r_lfsr;
    logic [2:0] r_target;
    logic [3:0] r_timer;
    logic [1:0] r_result;
    logic [1:0] r_p1_move;
    logic [1:0] r_p2_move;
    logic [2:0] r_p1_score;
    logic [2:0] r_p2_score;
    logic [3:0] r_round;
    logic [1:0] r_winner;
    logic       r_err_inv;
    logic       r_err_to;

    logic [1:0] w_opp_move;
    logic [2:0] w_p1_next;
    logic [2:0] w_p2_next;
    logic       w_lfsr_fb;

    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // A forced 11 passes straight through; only the pseudo-random source is folded onto stone.
    assign w_opp_move = force_en ? force_move
                                 : ((r_lfsr[1:0] == 2'b11) ? 2'b00 : r_lfsr[1:0]);

    // Scores are clamped at the target so they can never wrap.
    assign w_p1_next = ((r_result == 2'b01) && (r_p1_score < r_target)) ? r_p1_score + 3'd1 : r_p1_score;
    assign w_p2_next = ((r_result == 2'b10) && (r_p2_score < r_target)) ? r_p2_score + 3'd1 : r_p2_score;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_target   <= 3'd3;
            r_timer    <= 4'd0;
            r_result   <= 2'b00;
            r_p1_move  <= 2'b00;
            r_p2_move  <= 2'b00;
            r_p1_score <= 3'd0;
            r_p2_score <= 3'd0;
            r_round    <= 4'd0;
            r_winner   <= 2'b00;
            r_err_inv  <= 1'b0;
            r_err_to   <= 1'b0;
        end else if (new_match) begin
            r_state    <= S_IDLE;
            r_target   <= (target_cfg == 3'd0) ? 3'd1 : target_cfg;
            r_p1_score <= 3'd0;
            r_p2_score <= 3'd0;
            r_round    <= 4'd0;
            r_winner   <= 2'b00;
            r_err_inv  <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (p1_valid) begin
                        if (p1_move_in == 2'b11) begin
                            r_err_inv <= 1'b1;
                        end else begin
                            r_p1_move <= p1_move_in;
                            r_p2_move <= w_opp_move;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= 4'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A verdict arriving on the last allowed cycle wins over the timeout.
                    if (result_valid) begin
                        r_result <= result_in;
                        r_state  <= S_TALLY;
                    end else if (r_timer == 4'd15) begin
                        r_err_to <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 4'd1;
                    end
                end
                S_TALLY: begin
                    r_p1_score <= w_p1_next;
                    r_p2_score <= w_p2_next;
                    if (r_round != 4'd15) begin
                        r_round <= r_round + 4'd1;
                    end
                    if (r_result == 2'b11) begin
                        r_err_inv <= 1'b1;
                    end
                    if (w_p1_next == r_target) begin
                        r_winner <= 2'b01;
                        r_state  <= S_DONE;
                    end else if (w_p2_next == r_target) begin
                        r_winner <= 2'b10;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign eval_start   = (r_state == S_ISSUE);
    assign busy         = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_TALLY);
    assign match_done   = (r_state == S_DONE);
    assign p1_move_out  = r_p1_move;
    assign p2_move_out  = r_p2_move;
    assign p1_score     = r_p1_score;
    assign p2_score     = r_p2_score;
    assign round_cnt    = r_round;
    assign match_winner = r_winner;
    assign err_invalid  = r_err_inv;
    assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_rps_match_master.sv
// Bench for rps_match_master: a round-level model is compared against every output each cycle,
// and directed scenarios add literal checks at the points of interest.
module tb_rps_match_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_match = 1'b0;
    logic [2:0] target_cfg = 3'd0;
    logic       p1_valid = 1'b0;
    logic [1:0] p1_move_in = 2'b00;
    logic       force_en = 1'b0;
    logic [1:0] force_move = 2'b00;
    logic       eval_start;
    logic [1:0] p1_move_out, p2_move_out;
    logic [1:0] result_in = 2'b00;
    logic       result_valid = 1'b0;
    logic [2:0] p1_score, p2_score;
    logic [3:0] round_cnt;
    logic       match_done;
    logic [1:0] match_winner;
    logic       busy;
    logic       err_invalid, err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rps_match_master dut (
        .clk(clk), .reset(reset), .new_match(new_match), .target_cfg(target_cfg),
        .p1_valid(p1_valid), .p1_move_in(p1_move_in), .force_en(force_en), .force_move(force_move),
        .eval_start(eval_start), .p1_move_out(p1_move_out), .p2_move_out(p2_move_out),
        .result_in(result_in), .result_valid(result_valid),
        .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
        .match_done(match_done), .match_winner(match_winner), .busy(busy),
        .err_invalid(err_invalid), .err_timeout(err_timeout)
    );

    // Round-level model: a round is "active" from the issue cycle (age 0) through wait cycles 1..16,
    // after which a pending verdict is tallied on the following cycle.
    int m_lfsr, m_target, m_p1s, m_p2s, m_round, m_winner, m_err_inv, m_err_to;
    int m_p1mv, m_p2mv, m_age, m_verdict;
    bit m_active, m_tally, m_done;

    task automatic model_reset();
        m_lfsr = 'hA5; m_target = 3; m_p1s = 0; m_p2s = 0; m_round = 0; m_winner = 0;
        m_err_inv = 0; m_err_to = 0; m_p1mv = 0; m_p2mv = 0; m_age = 0; m_verdict = 0;
        m_active = 0; m_tally = 0; m_done = 0;
    endtask

    task automatic model_step();
        int opp;
        opp = force_en ? int'(force_move) : (((m_lfsr % 4) == 3) ? 0 : (m_lfsr % 4));
        if (new_match) begin
            m_target = (target_cfg == 0) ? 1 : int'(target_cfg);
            m_p1s = 0; m_p2s = 0; m_round = 0; m_winner = 0; m_err_inv = 0; m_err_to = 0;
            m_active = 0; m_tally = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 1;
        end else if (m_tally) begin
            m_tally = 0;
            if (m_round < 15) m_round = m_round + 1;
            if (m_verdict == 1 && m_p1s < m_target) m_p1s = m_p1s + 1;
            if (m_verdict == 2 && m_p2s < m_target) m_p2s = m_p2s + 1;
            if (m_verdict == 3) m_err_inv = 1;
            if (m_p1s == m_target) begin
                m_winner = 1; m_done = 1;
            end else if (m_p2s == m_target) begin
                m_winner = 2; m_done = 1;
            end
        end else if (m_active) begin
            if (m_age == 0) begin
                m_age = 1;
            end else if (result_valid) begin
                m_verdict = int'(result_in); m_tally = 1; m_active = 0;
            end else if (m_age == 16) begin
                m_err_to = 1; m_active = 0;
            end else begin
                m_age = m_age + 1;
            end
        end else if (p1_valid) begin
            if (p1_move_in == 2'b11) begin
                m_err_inv = 1;
            end else begin
                m_p1mv = int'(p1_move_in); m_p2mv = opp; m_active = 1; m_age = 0;
            end
        end
        m_lfsr = ((m_lfsr * 2) % 256) |
                 (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("eval_start",   int'(eval_start),   int'(m_active && m_age == 0));
            check("busy",         int'(busy),         int'(m_active || m_tally));
            check("match_done",   int'(match_done),   int'(m_done));
            check("p1_move_out",  int'(p1_move_out),  m_p1mv);
            check("p2_move_out",  int'(p2_move_out),  m_p2mv);
            check("p1_score",     int'(p1_score),     m_p1s);
            check("p2_score",     int'(p2_score),     m_p2s);
            check("round_cnt",    int'(round_cnt),    m_round);
            check("match_winner", int'(match_winner), m_winner);
            check("err_invalid",  int'(err_invalid),  m_err_inv);
            check("err_timeout",  int'(err_timeout),  m_err_to);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_match(input int cfg);
        new_match = 1'b1; target_cfg = 3'(cfg);
        tick(1);
        new_match = 1'b0;
    endtask

    // Verdict is presented during wait cycle d (1..16); d = 0 means no verdict at all.
    task automatic play(input int mv, input int res, input int d);
        p1_valid = 1'b1; p1_move_in = 2'(mv);
        tick(1);
        p1_valid = 1'b0;
        if (d == 0) begin
            tick(20);
        end else begin
            tick(d);
            result_valid = 1'b1; result_in = 2'(res);
            tick(1);
            result_valid = 1'b0;
            tick(2);
        end
        $display("round p1=%0d res=%0d d=%0d -> p1s=%0d p2s=%0d rnd=%0d done=%0d win=%0d ei=%0d et=%0d",
                 mv, res, d, p1_score, p2_score, round_cnt, match_done, match_winner,
                 err_invalid, err_timeout);
    endtask

    initial begin
        tick(2);
        #2 reset = 1'b0;
        tick(1);
        check("lit_reset_p1_score", int'(p1_score), 0);
        check("lit_reset_round", int'(round_cnt), 0);
        check("lit_reset_p2_move", int'(p2_move_out), 0);

        // Target 2, opponent forced to scissors, P1 wins twice
        force_en = 1'b1; force_move = 2'b10;
        start_match(2);
        play(1, 1, 1);
        check("lit_first_win_p1", int'(p1_score), 1);
        check("lit_first_win_done", int'(match_done), 0);
        check("lit_first_win_p2mv", int'(p2_move_out), 2);
        play(1, 1, 3);
        check("lit_match_p1", int'(p1_score), 2);
        check("lit_match_done", int'(match_done), 1);
        check("lit_match_winner", int'(match_winner), 1);
        play(0, 2, 1);
        check("lit_done_hold_p2", int'(p2_score), 0);
        check("lit_done_hold", int'(match_done), 1);

        // Illegal P1 move
        start_match(3);
        p1_valid = 1'b1; p1_move_in = 2'b11;
        tick(1);
        p1_valid = 1'b0;
        check("lit_illegal_eval", int'(eval_start), 0);
        tick(2);
        check("lit_illegal_err", int'(err_invalid), 1);
        check("lit_illegal_busy", int'(busy), 0);

        // Stray verdict in IDLE, then timeout
        start_match(3);
        result_valid = 1'b1; result_in = 2'b01;
        tick(1);
        result_valid = 1'b0;
        check("lit_stray_result", int'(p1_score), 0);
        play(2, 0, 0);
        check("lit_timeout_err", int'(err_timeout), 1);
        check("lit_timeout_round", int'(round_cnt), 0);
        check("lit_timeout_busy", int'(busy), 0);

        // Verdict on the 16th wait cycle, then invalid and tie verdicts
        start_match(3);
        play(0, 2, 16);
        check("lit_last_cycle_to", int'(err_timeout), 0);
        check("lit_last_cycle_p2", int'(p2_score), 1);
        check("lit_last_cycle_rnd", int'(round_cnt), 1);
        play(1, 3, 2);
        check("lit_inv_err", int'(err_invalid), 1);
        check("lit_inv_round", int'(round_cnt), 2);
        check("lit_inv_p2", int'(p2_score), 1);
        play(2, 0, 1);
        check("lit_tie_round", int'(round_cnt), 3);
        check("lit_tie_p1", int'(p1_score), 0);

        // new_match during WAIT with target 0 -> single win decides
        p1_valid = 1'b1; p1_move_in = 2'b00;
        tick(1);
        p1_valid = 1'b0;
        tick(3);
        start_match(0);
        check("lit_abort_busy", int'(busy), 0);
        check("lit_abort_round", int'(round_cnt), 0);
        check("lit_abort_err", int'(err_invalid), 0);
        tick(20);
        play(0, 2, 1);
        check("lit_t0_winner", int'(match_winner), 2);
        check("lit_t0_done", int'(match_done), 1);

        // LFSR-driven opponent and forced illegal opponent move
        start_match(7);
        force_en = 1'b0;
        for (int i = 0; i < 5; i++) play(i % 3, 0, 1 + i);
        force_en = 1'b1; force_move = 2'b11;
        play(1, 0, 1);
        check("lit_forced_11", int'(p2_move_out), 3);

        // round_cnt saturation
        for (int i = 0; i < 12; i++) play(0, 0, 1);
        check("lit_round_sat", int'(round_cnt), 15);

        // Reset during the issue cycle leaves nothing pending
        p1_valid = 1'b1; p1_move_in = 2'b01;
        tick(1);
        p1_valid = 1'b0;
        #2 reset = 1'b1;
        tick(1);
        check("lit_rst_eval", int'(eval_start), 0);
        check("lit_rst_round", int'(round_cnt), 0);
        #2 reset = 1'b0;
        tick(2);
        check("lit_rst_eval_after", int'(eval_start), 0);
        check("lit_rst_busy_after", int'(busy), 0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rps_match_master.md
RPS_MATCH_MASTER -- requirements
Module: rps_match_master

Interface
REQ-001 clk  in  1  system clock, all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clock clk.
REQ-003 new_match  in  1  1-cycle pulse; clears scores and errors, latches target.
REQ-004 target_cfg  in  3  wins needed to take the match; 0 treated as 1.
REQ-005 p1_valid  in  1  1-cycle strobe qualifying p1_move_in.
REQ-006 p1_move_in  in  2  00 stone, 01 paper, 10 scissors, 11 illegal.
REQ-007 force_en  in  1  1 = opponent move taken from force_move, not the LFSR.
REQ-008 force_move  in  2  opponent move used when force_en=1.
REQ-009 eval_start  out  1  1-cycle pulse, round moves are valid for the evaluator.
REQ-010 p1_move_out, p2_move_out  out  2 each  round moves, stable from ISSUE through TALLY.
REQ-011 result_in  in  2  evaluator verdict: 00 tie, 01 P1 wins, 10 P2 wins, 11 invalid.
REQ-012 result_valid  in  1  qualifies result_in.
REQ-013 p1_score, p2_score  out  3 each  round wins this match.
REQ-014 round_cnt  out  4  rounds tallied, saturates at 15.
REQ-015 match_done  out  1  level, high in DONE.
REQ-016 match_winner  out  2  00 none, 01 P1, 10 P2.
REQ-017 busy  out  1  high in ISSUE, WAIT, TALLY.
REQ-018 err_invalid, err_timeout  out  1 each  sticky error flags.

Function
REQ-019 States: IDLE, ISSUE, WAIT, TALLY, DONE; one-hot or binary, implementer's choice.
REQ-020 LFSR: 8-bit, reset value 8'hA5, advances every cycle; shift left with bit0 = l[7]^l[5]^l[4]^l[3].
REQ-021 Opponent move = force_move if force_en=1, else lfsr[1:0], with 11 mapped to 00; a forced 11 is passed through unchanged.
REQ-022 IDLE: p1_valid=1 and p1_move_in!=11 latches p1_move_in and the opponent move, then goes to ISSUE next cycle.
REQ-023 IDLE: p1_valid=1 and p1_move_in=11 sets err_invalid, stays in IDLE, and issues no eval_start.
REQ-024 p1_valid outside IDLE is ignored.
REQ-025 ISSUE: eval_start=1 for exactly this cycle, 16-cycle wait timer cleared, go to WAIT.
REQ-026 WAIT: result_valid=1 captures result_in and goes to TALLY.
REQ-027 WAIT timeout: on the 16th WAIT cycle without result_valid, set err_timeout and return to IDLE; no score change, no round_cnt change.
REQ-028 result_valid in the same cycle as timeout expiry: result accepted, no timeout.
REQ-029 result_valid outside WAIT is ignored.
REQ-030 TALLY action by verdict: 01 increments p1_score; 10 increments p2_score; 00 changes no score; 11 sets err_invalid and changes no score.
REQ-031 TALLY increments round_cnt (saturating) for every verdict, including 11.
REQ-032 TALLY next state: DONE if the updated p1_score or p2_score equals the effective target, with match_winner set to the winner; otherwise IDLE.
REQ-033 Scores are 3-bit, never exceed target, and never wrap.
REQ-034 DONE: match_done=1, holds scores and winner, ignores p1_valid and result_valid.
REQ-035 new_match in any state, one cycle: state to IDLE; scores, round_cnt, match_winner, errors cleared; target latched from target_cfg; LFSR unaffected.
REQ-036 new_match has priority over all other events in that cycle, including mid-round.
REQ-037 Latency: eval_start is asserted 1 cycle after accepted p1_valid; scores update 2 cycles after accepted result_valid.

Reset
REQ-038 Reset forces IDLE, LFSR=8'hA5, target=3; all outputs 0; p1_move_out and p2_move_out = 00.
REQ-039 Reset deassertion mid-round leaves no pending eval_start.

Verification
REQ-040 Setup: reset, new_match with target_cfg=2, force_en=1, force_move=10; p1 01 with result 01 -> p1_score=1, no done; repeat -> p1_score=2, match_done=1, match_winner=01.
REQ-041 p1_valid with p1_move_in=11 -> err_invalid=1, eval_start never asserted, state stays IDLE.
REQ-042 Round issued, no result_valid for 16 cycles -> err_timeout=1, back to IDLE, scores unchanged, round_cnt unchanged.
REQ-043 result_valid in the 16th WAIT cycle -> accepted, err_timeout=0.
REQ-044 Result 11 -> err_invalid=1, round_cnt+1, scores unchanged; result 00 -> round_cnt+1 only.
REQ-045 new_match asserted during WAIT -> IDLE next cycle, all counters 0; target_cfg=0 -> a single P2 win gives match_winner=10.
